// File: rtl/level_controller.sv
// rtl/level_controller.sv - game-flow state machine tracking lives, level and palette
//
// Purpose: sequences the game through IDLE, PLAY, HIT (collision penalty pause),
// LVLUP (level-transition pause), OVER and WON. All game events are evaluated
// once per video frame, on a one-cycle pulse derived from the frame_clk rising edge.
//
// Ports:
//   Clk                  system clock
//   Reset                synchronous, active-high reset
//   frame_clk            vertical-sync level, synchronous to Clk
//   collision            player/obstacle overlap flag
//   finish_line_reached  player-at-finish flag
//   start                start/restart request, level-sensitive
//   current_level        active level index
//   foreground           obstacle palette code
//   background           playfield palette code
//   reset_player         holds the ball at its start position while high
//   lives                remaining lives
//   game_over            high only in OVER
//   game_won             high only in WON

module level_controller #(
  parameter int LIVES_INIT = 3,
  parameter int NUM_LEVELS = 3,
  parameter int HIT_FRAMES = 30,
  parameter int LVL_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       collision,
  input  logic       finish_line_reached,
  input  logic       start,
  output logic [1:0] current_level,
  output logic [3:0] foreground,
  output logic [3:0] background,
  output logic       reset_player,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       game_won
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    HIT   = 3'd2,
    LVLUP = 3'd3,
    OVER  = 3'd4,
    WON   = 3'd5
  } state_t;

  localparam logic [6:0] HIT_LAST   = 7'(HIT_FRAMES - 1);
  localparam logic [6:0] LVL_LAST   = 7'(LVL_FRAMES - 1);
  localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
  localparam logic [1:0] LIVES_RST  = 2'(LIVES_INIT);

  state_t     state, state_d;
  logic       frame_clk_q;
  logic       frame_tick;
  logic [6:0] frame_cnt, frame_cnt_d;
  logic [1:0] level_d, lives_d;
  logic [3:0] palette_d;
  logic       reset_player_d, game_over_d, game_won_d;

  // Frame edge detector. The delayed sample keeps tracking frame_clk during
  // reset, so a frame_clk already high when reset releases is not mistaken
  // for a fresh rising edge; only the tick pulse itself is forced low.
  always_ff @(posedge Clk) begin
    frame_clk_q <= frame_clk;
    if (Reset) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_clk & ~frame_clk_q;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      frame_cnt     <= 7'd0;
      current_level <= 2'd0;
      lives         <= LIVES_RST;
      foreground    <= 4'd3;
      background    <= 4'd3;
      reset_player  <= 1'b1;
      game_over     <= 1'b0;
      game_won      <= 1'b0;
    end else begin
      state         <= state_d;
      frame_cnt     <= frame_cnt_d;
      current_level <= level_d;
      lives         <= lives_d;
      foreground    <= palette_d;
      background    <= palette_d;
      reset_player  <= reset_player_d;
      game_over     <= game_over_d;
      game_won      <= game_won_d;
    end
  end

  // Next-state, lives, level and pause counter.
  always_comb begin
    state_d = state;
    level_d = current_level;
    lives_d = lives;
    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_d = PLAY;
            lives_d = LIVES_RST;
            level_d = 2'd0;
          end
        end
        PLAY: begin
          // Collision wins over a finish seen on the same frame.
          if (collision) begin
            if (lives > 2'd1) begin
              state_d = HIT;
              lives_d = lives - 2'd1;
            end else begin
              state_d = OVER;
              lives_d = 2'd0;
            end
          end else if (finish_line_reached) begin
            if (current_level < LAST_LEVEL) begin
              state_d = LVLUP;
              level_d = current_level + 2'd1;
            end else begin
              state_d = WON;
            end
          end
        end
        HIT: begin
          if (frame_cnt == HIT_LAST) state_d = PLAY;
        end
        LVLUP: begin
          if (frame_cnt == LVL_LAST) state_d = PLAY;
        end
        OVER, WON: begin
          if (start) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Counter restarts on any state change so each pause starts from zero.
    if (state_d != state) begin
      frame_cnt_d = 7'd0;
    end else if (frame_tick && (state == HIT || state == LVLUP)) begin
      frame_cnt_d = frame_cnt + 7'd1;
    end else begin
      frame_cnt_d = frame_cnt;
    end
  end

  // Output values computed from the upcoming state so they register alongside it.
  always_comb begin
    reset_player_d = (state_d != PLAY);
    game_over_d    = (state_d == OVER);
    game_won_d     = (state_d == WON);
    case (level_d)
      2'd0:    palette_d = 4'd3;
      2'd1:    palette_d = 4'd6;
      2'd2:    palette_d = 4'd10;
      default: palette_d = 4'd0;
    endcase
  end

endmodule

// File: tb/tb_level_controller.sv
// tb/tb_level_controller.sv - directed self-checking bench for level_controller

module tb_level_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_clk;
  logic       collision;
  logic       finish;
  logic       start;
  logic [1:0] current_level;
  logic [3:0] foreground;
  logic [3:0] background;
  logic       reset_player;
  logic [1:0] lives;
  logic       game_over;
  logic       game_won;

  int total = 0;
  int bad   = 0;

  level_controller dut (
    .Clk                 (clk),
    .Reset               (rst),
    .frame_clk           (frame_clk),
    .collision           (collision),
    .finish_line_reached (finish),
    .start               (start),
    .current_level       (current_level),
    .foreground          (foreground),
    .background          (background),
    .reset_player        (reset_player),
    .lives               (lives),
    .game_over           (game_over),
    .game_won            (game_won)
  );

  always #5 clk = ~clk;

  // One video frame: frame_clk high two cycles, low two cycles. The FSM has
  // acted on the tick by the time this returns (on a falling clock edge).
  task automatic do_tick();
    @(negedge clk);
    frame_clk = 1'b1;
    repeat (2) @(negedge clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Frames spent with reset_player high before returning to PLAY.
  task automatic wait_pause(output int n);
    n = 0;
    while (reset_player && n < 80) begin
      do_tick();
      n++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (lives !== 2'd3) begin bad++; $display("FAIL reset_lives: got %0d want 3", lives); end
    total++; if (current_level !== 2'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", current_level); end
    total++; if (foreground !== 4'd3 || background !== 4'd3) begin bad++; $display("FAIL reset_palette: got fg=%0d bg=%0d want 3/3", foreground, background); end
    total++; if (reset_player !== 1'b1) begin bad++; $display("FAIL reset_rp: got %b want 1", reset_player); end
    total++; if (game_over !== 1'b0 || game_won !== 1'b0) begin bad++; $display("FAIL reset_flags: got over=%b won=%b want 0/0", game_over, game_won); end
    do_tick();
    total++; if (reset_player !== 1'b1) begin bad++; $display("FAIL idle_hold: got rp=%b want 1", reset_player); end
  endtask

  task automatic test_start();
    start = 1'b1;
    do_tick();
    start = 1'b0;
    total++; if (reset_player !== 1'b0) begin bad++; $display("FAIL start_rp: got %b want 0", reset_player); end
    total++; if (lives !== 2'd3 || current_level !== 2'd0) begin bad++; $display("FAIL start_state: got lives=%0d lvl=%0d want 3/0", lives, current_level); end
    total++; if (foreground !== 4'd3 || background !== 4'd3) begin bad++; $display("FAIL start_palette: got fg=%0d bg=%0d want 3/3", foreground, background); end
  endtask

  task automatic test_collision();
    int n;
    collision = 1'b1;
    do_tick();
    total++; if (lives !== 2'd2 || reset_player !== 1'b1) begin bad++; $display("FAIL hit_entry: got lives=%0d rp=%b want 2/1", lives, reset_player); end
    // collision stays high through the pause and must be ignored
    wait_pause(n);
    collision = 1'b0;
    total++; if (n !== 30) begin bad++; $display("FAIL hit_len: got %0d frames want 30", n); end
    total++; if (lives !== 2'd2) begin bad++; $display("FAIL hit_ignore: got lives=%0d want 2", lives); end
  endtask

  task automatic test_game_over();
    int n;
    collision = 1'b1;
    do_tick();
    collision = 1'b0;
    total++; if (lives !== 2'd1) begin bad++; $display("FAIL second_hit: got lives=%0d want 1", lives); end
    wait_pause(n);
    total++; if (n !== 30) begin bad++; $display("FAIL second_hit_len: got %0d frames want 30", n); end
    collision = 1'b1;
    do_tick();
    total++; if (lives !== 2'd0 || game_over !== 1'b1 || reset_player !== 1'b1 || game_won !== 1'b0) begin bad++; $display("FAIL over_entry: got lives=%0d over=%b rp=%b won=%b want 0/1/1/0", lives, game_over, reset_player, game_won); end
    do_tick();
    collision = 1'b0;
    total++; if (lives !== 2'd0 || game_over !== 1'b1) begin bad++; $display("FAIL over_hold: got lives=%0d over=%b want 0/1", lives, game_over); end
    start = 1'b1;
    do_tick();
    total++; if (game_over !== 1'b0 || reset_player !== 1'b1) begin bad++; $display("FAIL over_restart: got over=%b rp=%b want 0/1", game_over, reset_player); end
    do_tick();
    start = 1'b0;
    total++; if (lives !== 2'd3 || reset_player !== 1'b0 || current_level !== 2'd0) begin bad++; $display("FAIL replay: got lives=%0d rp=%b lvl=%0d want 3/0/0", lives, reset_player, current_level); end
  endtask

  task automatic test_levels();
    int n;
    finish = 1'b1;
    do_tick();
    total++; if (current_level !== 2'd1 || foreground !== 4'd6 || background !== 4'd6 || reset_player !== 1'b1) begin bad++; $display("FAIL lvl1_entry: got lvl=%0d fg=%0d bg=%0d rp=%b want 1/6/6/1", current_level, foreground, background, reset_player); end
    wait_pause(n);
    total++; if (n !== 60 || current_level !== 2'd1) begin bad++; $display("FAIL lvl1_len: got %0d frames lvl=%0d want 60/1", n, current_level); end
    do_tick();
    total++; if (current_level !== 2'd2 || foreground !== 4'd10 || background !== 4'd10) begin bad++; $display("FAIL lvl2_entry: got lvl=%0d fg=%0d bg=%0d want 2/10/10", current_level, foreground, background); end
    wait_pause(n);
    total++; if (n !== 60) begin bad++; $display("FAIL lvl2_len: got %0d frames want 60", n); end
    do_tick();
    finish = 1'b0;
    total++; if (game_won !== 1'b1 || game_over !== 1'b0 || reset_player !== 1'b1 || current_level !== 2'd2) begin bad++; $display("FAIL won_entry: got won=%b over=%b rp=%b lvl=%0d want 1/0/1/2", game_won, game_over, reset_player, current_level); end
    do_tick();
    total++; if (game_won !== 1'b1) begin bad++; $display("FAIL won_hold: got won=%b want 1", game_won); end
    start = 1'b1;
    do_tick();
    start = 1'b0;
    total++; if (game_won !== 1'b0 || reset_player !== 1'b1) begin bad++; $display("FAIL won_restart: got won=%b rp=%b want 0/1", game_won, reset_player); end
  endtask

  task automatic test_simultaneous();
    int n;
    start = 1'b1;
    do_tick();
    start = 1'b0;
    finish = 1'b1;
    do_tick();
    finish = 1'b0;
    wait_pause(n);
    collision = 1'b1;
    finish = 1'b1;
    do_tick();
    collision = 1'b0;
    finish = 1'b0;
    total++; if (lives !== 2'd2 || current_level !== 2'd1 || foreground !== 4'd6) begin bad++; $display("FAIL simul_state: got lives=%0d lvl=%0d fg=%0d want 2/1/6", lives, current_level, foreground); end
    total++; if (reset_player !== 1'b1 || game_won !== 1'b0) begin bad++; $display("FAIL simul_flags: got rp=%b won=%b want 1/0", reset_player, game_won); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    start = 1'b1;
    do_tick();
    start = 1'b0;
    finish = 1'b1;
    do_tick();
    finish = 1'b0;
    repeat (20) do_tick();
    total++; if (dut.frame_cnt !== 7'd20 || reset_player !== 1'b1) begin bad++; $display("FAIL mid_count: got cnt=%0d rp=%b want 20/1", dut.frame_cnt, reset_player); end
    @(negedge clk);
    rst = 1'b1;
    frame_clk = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (lives !== 2'd3 || current_level !== 2'd0 || foreground !== 4'd3 || background !== 4'd3) begin bad++; $display("FAIL mid_reset_vals: got lives=%0d lvl=%0d fg=%0d bg=%0d want 3/0/3/3", lives, current_level, foreground, background); end
    total++; if (reset_player !== 1'b1 || game_over !== 1'b0 || game_won !== 1'b0 || dut.frame_cnt !== 7'd0) begin bad++; $display("FAIL mid_reset_ctl: got rp=%b over=%b won=%b cnt=%0d want 1/0/0/0", reset_player, game_over, game_won, dut.frame_cnt); end
    repeat (8) @(negedge clk);
    total++; if (reset_player !== 1'b1) begin bad++; $display("FAIL no_spurious_tick: got rp=%b want 1", reset_player); end
    frame_clk = 1'b0;
    do_tick();
    start = 1'b0;
    total++; if (reset_player !== 1'b0 || current_level !== 2'd0) begin bad++; $display("FAIL post_reset_play: got rp=%b lvl=%0d want 0/0", reset_player, current_level); end
  endtask

  initial begin
    rst = 1'b1;
    frame_clk = 1'b0;
    collision = 1'b0;
    finish = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_start();
    test_collision();
    test_game_over();
    test_levels();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
